// File: rtl/sm_fifo_pair_if.sv
// Host-side and machine-side signals of one PIO state machine's TX/RX FIFO pair.
// The master modport drives requests and data; the slave modport is the FIFO pair itself.
interface sm_fifo_pair_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(2 * DEPTH) + 1;

  logic [WIDTH-1:0] tx_wdata;
  logic             tx_wr;
  logic             tx_full;
  logic [LW-1:0]    tx_level;
  logic [WIDTH-1:0] rx_rdata;
  logic             rx_rd;
  logic             rx_empty;
  logic [LW-1:0]    rx_level;
  logic             mach_stb;
  logic             mach_pull;
  logic [WIDTH-1:0] mach_din;
  logic             mach_empty;
  logic             mach_push;
  logic [WIDTH-1:0] mach_dout;
  logic             mach_full;
  logic             join_tx;
  logic             join_rx;
  logic             flush;
  logic             flag_clr;
  logic             tx_over;
  logic             rx_under;
  logic             tx_stall;
  logic             rx_stall;

  modport master (
    output tx_wdata, tx_wr, rx_rd, mach_stb, mach_pull, mach_push, mach_dout,
           join_tx, join_rx, flush, flag_clr,
    input  tx_full, tx_level, rx_rdata, rx_empty, rx_level, mach_din, mach_empty,
           mach_full, tx_over, rx_under, tx_stall, rx_stall
  );

  modport slave (
    input  tx_wdata, tx_wr, rx_rd, mach_stb, mach_pull, mach_push, mach_dout,
           join_tx, join_rx, flush, flag_clr,
    output tx_full, tx_level, rx_rdata, rx_empty, rx_level, mach_din, mach_empty,
           mach_full, tx_over, rx_under, tx_stall, rx_stall
  );
endinterface

// File: rtl/sm_fifo_pair.sv
// TX (host->machine) and RX (machine->host) FIFOs for one PIO state machine, sharing one
// 2*DEPTH storage array so either direction can be joined to take the full capacity.
module sm_fifo_pair #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  sm_fifo_pair_if.slave bus
);
  localparam int CAP = 2 * DEPTH;
  localparam int AW  = $clog2(CAP);
  localparam int LW  = AW + 1;

  typedef enum logic [1:0] {
    MODE_SPLIT,
    MODE_JOIN_TX,
    MODE_JOIN_RX
  } mode_e;

  // TX owns storage [0, DEPTH), RX owns [DEPTH, CAP); a joined side addresses all of it.
  logic [WIDTH-1:0] mem [CAP];

  logic [AW-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
  logic [LW-1:0] tx_cnt, rx_cnt;
  logic          join_tx_q, join_rx_q;
  logic          tx_over_q, rx_under_q, tx_stall_q, rx_stall_q;

  mode_e         mode;
  logic [LW-1:0] tx_cap, rx_cap;
  logic          tx_full_i, tx_empty_i, rx_full_i, rx_empty_i;
  logic          clear;
  logic          tx_push, tx_pop, rx_push, rx_pop;
  logic [AW-1:0] rx_waddr, rx_raddr;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr, input logic [LW-1:0] cap);
    return ({1'b0, ptr} + LW'(1) == cap) ? '0 : ptr + AW'(1);
  endfunction

  always_comb begin
    mode = MODE_SPLIT;
    if (join_tx_q)      mode = MODE_JOIN_TX;
    else if (join_rx_q) mode = MODE_JOIN_RX;
  end

  // A disabled side gets capacity 0, which makes it read as both full and empty.
  always_comb begin
    tx_cap = LW'(DEPTH);
    rx_cap = LW'(DEPTH);
    unique case (mode)
      MODE_JOIN_TX: begin tx_cap = LW'(CAP); rx_cap = '0;       end
      MODE_JOIN_RX: begin tx_cap = '0;       rx_cap = LW'(CAP); end
      default:      ;
    endcase
  end

  assign tx_full_i  = (tx_cnt == tx_cap);
  assign tx_empty_i = (tx_cnt == '0);
  assign rx_full_i  = (rx_cnt == rx_cap);
  assign rx_empty_i = (rx_cnt == '0);

  // A join change re-maps the storage, so it empties both FIFOs just like flush.
  assign clear = bus.flush | (bus.join_tx != join_tx_q) | (bus.join_rx != join_rx_q);

  // Full/empty come from the current level only: a same-cycle pop never makes room.
  assign tx_push = bus.tx_wr & ~tx_full_i & ~clear;
  assign tx_pop  = bus.mach_stb & bus.mach_pull & ~tx_empty_i & ~clear;
  assign rx_push = bus.mach_stb & bus.mach_push & ~rx_full_i & ~clear;
  assign rx_pop  = bus.rx_rd & ~rx_empty_i & ~clear;

  assign rx_waddr = rx_wptr + AW'(DEPTH);
  assign rx_raddr = rx_rptr + AW'(DEPTH);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wptr    <= '0;
      tx_rptr    <= '0;
      rx_wptr    <= '0;
      rx_rptr    <= '0;
      tx_cnt     <= '0;
      rx_cnt     <= '0;
      join_tx_q  <= 1'b0;
      join_rx_q  <= 1'b0;
      tx_over_q  <= 1'b0;
      rx_under_q <= 1'b0;
      tx_stall_q <= 1'b0;
      rx_stall_q <= 1'b0;
    end else begin
      join_tx_q <= bus.join_tx;
      join_rx_q <= bus.join_rx;

      if (clear) begin
        tx_wptr <= '0;
        tx_rptr <= '0;
        rx_wptr <= '0;
        rx_rptr <= '0;
        tx_cnt  <= '0;
        rx_cnt  <= '0;
      end else begin
        if (tx_push) tx_wptr <= ptr_inc(tx_wptr, tx_cap);
        if (tx_pop)  tx_rptr <= ptr_inc(tx_rptr, tx_cap);
        if (rx_push) rx_wptr <= ptr_inc(rx_wptr, rx_cap);
        if (rx_pop)  rx_rptr <= ptr_inc(rx_rptr, rx_cap);
        tx_cnt <= tx_cnt + LW'(tx_push) - LW'(tx_pop);
        rx_cnt <= rx_cnt + LW'(rx_push) - LW'(rx_pop);
      end

      // Clear wins over a same-cycle set.
      if (bus.flag_clr) begin
        tx_over_q  <= 1'b0;
        rx_under_q <= 1'b0;
        tx_stall_q <= 1'b0;
        rx_stall_q <= 1'b0;
      end else begin
        if (bus.tx_wr & tx_full_i)                    tx_over_q  <= 1'b1;
        if (bus.rx_rd & rx_empty_i)                   rx_under_q <= 1'b1;
        if (bus.mach_stb & bus.mach_pull & tx_empty_i) tx_stall_q <= 1'b1;
        if (bus.mach_stb & bus.mach_push & rx_full_i)  rx_stall_q <= 1'b1;
      end
    end
  end

  // NOTE: storage has no reset; the level counters alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (tx_push) mem[tx_wptr]  <= bus.tx_wdata;
    if (rx_push) mem[rx_waddr] <= bus.mach_dout;
  end

  assign bus.tx_full    = tx_full_i;
  assign bus.tx_level   = tx_cnt;
  assign bus.mach_empty = tx_empty_i;
  assign bus.mach_din   = tx_empty_i ? '0 : mem[tx_rptr];
  assign bus.mach_full  = rx_full_i;
  assign bus.rx_empty   = rx_empty_i;
  assign bus.rx_level   = rx_cnt;
  assign bus.rx_rdata   = rx_empty_i ? '0 : mem[rx_raddr];
  assign bus.tx_over    = tx_over_q;
  assign bus.rx_under   = rx_under_q;
  assign bus.tx_stall   = tx_stall_q;
  assign bus.rx_stall   = rx_stall_q;
endmodule

// File: tb/tb_sm_fifo_pair.sv
// Directed bench for sm_fifo_pair: TX/RX ordering, full/empty boundaries, sticky flags,
// join modes, flush and reset.
module tb_sm_fifo_pair;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  sm_fifo_pair_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  sm_fifo_pair #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs are applied 1 ns after an edge; one call advances past the next edge and
  // returns the strobes to idle. Outputs are checked right after it returns.
  task automatic cycle();
    @(posedge clk);
    #1;
    bus.tx_wr     = 1'b0;
    bus.rx_rd     = 1'b0;
    bus.mach_stb  = 1'b0;
    bus.mach_pull = 1'b0;
    bus.mach_push = 1'b0;
    bus.flush     = 1'b0;
    bus.flag_clr  = 1'b0;
  endtask

  task automatic host_write(input logic [31:0] d);
    bus.tx_wdata = d;
    bus.tx_wr    = 1'b1;
    cycle();
  endtask

  task automatic mach_pull_one();
    bus.mach_stb  = 1'b1;
    bus.mach_pull = 1'b1;
    cycle();
  endtask

  task automatic mach_push_one(input logic [31:0] d);
    bus.mach_dout = d;
    bus.mach_stb  = 1'b1;
    bus.mach_push = 1'b1;
    cycle();
  endtask

  logic [31:0] tx_vec [4];

  initial begin
    checks = 0;
    errors = 0;
    tx_vec[0] = 32'h11; tx_vec[1] = 32'h22; tx_vec[2] = 32'h33; tx_vec[3] = 32'h44;
    reset = 1'b1;
    bus.tx_wdata = '0; bus.tx_wr = 0; bus.rx_rd = 0; bus.mach_stb = 0; bus.mach_pull = 0;
    bus.mach_push = 0; bus.mach_dout = '0; bus.join_tx = 0; bus.join_rx = 0;
    bus.flush = 0; bus.flag_clr = 0;
    cycle(); cycle();
    reset = 1'b0;
    cycle();

    check("rst_tx_full",    bus.tx_full,    0);
    check("rst_mach_empty", bus.mach_empty, 1);
    check("rst_rx_empty",   bus.rx_empty,   1);
    check("rst_mach_full",  bus.mach_full,  0);
    check("rst_levels",     {bus.tx_level, bus.rx_level}, 0);
    check("rst_flags",      {bus.tx_over, bus.rx_under, bus.tx_stall, bus.rx_stall}, 0);
    check("rst_mach_din",   bus.mach_din,   0);
    check("rst_rx_rdata",   bus.rx_rdata,   0);

    // Fill TX, overflow, drain in order.
    for (int i = 0; i < 4; i++) begin
      host_write(tx_vec[i]);
      check("tx_fill_level", bus.tx_level, i + 1);
    end
    check("tx_full_at4",  bus.tx_full,  1);
    check("tx_head_fwft", bus.mach_din, 32'h11);
    host_write(32'h55);
    check("tx_over_set",  bus.tx_over,  1);
    check("tx_level_ovf", bus.tx_level, 4);
    for (int i = 0; i < 4; i++) begin
      check("tx_order", bus.mach_din, tx_vec[i]);
      mach_pull_one();
    end
    check("tx_drained_empty", bus.mach_empty, 1);
    check("tx_drained_din",   bus.mach_din,   0);

    // Pull on empty, flag clearing and its priority, strobe qualification.
    mach_pull_one();
    check("stall_level", bus.tx_level, 0);
    check("stall_set",   bus.tx_stall, 1);
    bus.flag_clr = 1'b1;
    cycle();
    check("flag_clr_stall", bus.tx_stall, 0);
    check("flag_clr_over",  bus.tx_over,  0);
    bus.flag_clr = 1'b1;
    mach_pull_one();
    check("flag_clr_prio", bus.tx_stall, 0);
    bus.mach_pull = 1'b1;
    cycle();
    check("no_stb_no_flag", bus.tx_stall, 0);

    // Full TX with write and pull in the same cycle: write is dropped.
    for (int i = 0; i < 4; i++) host_write(32'hA0 + i);
    bus.tx_wdata = 32'h99; bus.tx_wr = 1'b1;
    bus.mach_stb = 1'b1;   bus.mach_pull = 1'b1;
    cycle();
    check("full_wr_pull_level", bus.tx_level, 3);
    check("full_wr_pull_over",  bus.tx_over,  1);
    for (int i = 1; i < 4; i++) begin
      check("full_wr_pull_order", bus.mach_din, 32'hA0 + i);
      mach_pull_one();
    end
    check("full_wr_pull_empty", bus.mach_empty, 1);

    // Push+pop on empty, then on a non-empty non-full FIFO.
    bus.tx_wdata = 32'h5A; bus.tx_wr = 1'b1;
    bus.mach_stb = 1'b1;   bus.mach_pull = 1'b1;
    cycle();
    check("empty_pp_level", bus.tx_level, 1);
    check("empty_pp_head",  bus.mach_din, 32'h5A);
    bus.tx_wdata = 32'h6B; bus.tx_wr = 1'b1;
    bus.mach_stb = 1'b1;   bus.mach_pull = 1'b1;
    cycle();
    check("mid_pp_level", bus.tx_level, 1);
    check("mid_pp_head",  bus.mach_din, 32'h6B);
    mach_pull_one();
    bus.flag_clr = 1'b1;
    cycle();

    // RX read while empty.
    bus.rx_rd = 1'b1;
    cycle();
    check("rx_under_set",   bus.rx_under, 1);
    check("rx_under_level", bus.rx_level, 0);

    // Join RX: 8 entries, TX disabled.
    bus.join_rx = 1'b1;
    cycle();
    check("jrx_tx_full",  bus.tx_full,    1);
    check("jrx_tx_empty", bus.mach_empty, 1);
    check("jrx_tx_level", bus.tx_level,   0);
    for (int i = 0; i < 8; i++) mach_push_one(i);
    check("jrx_level8",    bus.rx_level,  8);
    check("jrx_mach_full", bus.mach_full, 1);
    mach_push_one(32'h99);
    check("jrx_stall",     bus.rx_stall,  1);
    check("jrx_level_ovf", bus.rx_level,  8);
    for (int i = 0; i < 8; i++) begin
      check("jrx_order", bus.rx_rdata, i);
      bus.rx_rd = 1'b1;
      cycle();
    end
    check("jrx_drained", bus.rx_empty, 1);
    bus.flag_clr = 1'b1;
    cycle();
    host_write(32'h77);
    check("jrx_tx_disabled_over", bus.tx_over,  1);
    check("jrx_tx_disabled_lvl",  bus.tx_level, 0);

    // Back to split, RX at level 2, then toggle join_tx.
    bus.join_rx = 1'b0;
    cycle();
    mach_push_one(32'hC0);
    mach_push_one(32'hC1);
    check("split_rx_level2", bus.rx_level, 2);
    check("split_rx_head",   bus.rx_rdata, 32'hC0);
    bus.join_tx = 1'b1;
    cycle();
    check("jtx_rx_level0",   bus.rx_level,  0);
    check("jtx_rx_empty",    bus.rx_empty,  1);
    check("jtx_mach_full",   bus.mach_full, 1);
    check("jtx_tx_level0",   bus.tx_level,  0);
    for (int i = 0; i < 8; i++) host_write(32'hD0 + i);
    check("jtx_tx_level8", bus.tx_level, 8);
    check("jtx_tx_full",   bus.tx_full,  1);
    check("jtx_tx_head",   bus.mach_din, 32'hD0);
    bus.join_tx = 1'b0;
    cycle();
    check("unjoin_flush", bus.tx_level, 0);

    // Flush empties data but keeps flags.
    host_write(32'hE0);
    host_write(32'hE1);
    bus.flush = 1'b1;
    cycle();
    check("flush_level", bus.tx_level,   0);
    check("flush_empty", bus.mach_empty, 1);
    check("flush_keeps_flag", bus.tx_over, 1);

    // Reset with 3 words in TX and flags set.
    host_write(32'hF0);
    host_write(32'hF1);
    host_write(32'hF2);
    bus.rx_rd = 1'b1;
    mach_push_one(32'h1);
    check("pre_rst_level", bus.tx_level, 3);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("rst2_mach_empty", bus.mach_empty, 1);
    check("rst2_tx_level",   bus.tx_level,   0);
    check("rst2_rx_level",   bus.rx_level,   0);
    check("rst2_flags", {bus.tx_over, bus.rx_under, bus.tx_stall, bus.rx_stall}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
